// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: control bus layout, WD_SEL/LD_TYPE codes
// and the load-data extender.
package wb_stage_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam int CTL_A3_LSB  = 0;
  localparam int CTL_A3_MSB  = 4;
  localparam int CTL_WDS_LSB = 5;
  localparam int CTL_WDS_MSB = 7;
  localparam int CTL_LDT_LSB = 8;
  localparam int CTL_LDT_MSB = 10;
  localparam int CTL_REG_WE  = 11;

  typedef enum logic [2:0] {
    WD_SEL_AO   = 3'd0,
    WD_SEL_DR   = 3'd1,
    WD_SEL_PC8  = 3'd2,
    WD_SEL_HILO = 3'd3
  } wd_sel_e;

  typedef enum logic [2:0] {
    LD_TYPE_LW  = 3'd0,
    LD_TYPE_LB  = 3'd1,
    LD_TYPE_LBU = 3'd2,
    LD_TYPE_LH  = 3'd3,
    LD_TYPE_LHU = 3'd4
  } ld_type_e;

  // Codes outside the enum (5..7) fall through to LW.
  function automatic logic [31:0] ld_ext(input logic [2:0] ld_type,
                                         input logic [1:0] off,
                                         input logic [31:0] dr);
    logic [7:0]  b;
    logic [15:0] h;
    b = dr[{off, 3'b000} +: 8];
    h = off[1] ? dr[31:16] : dr[15:0];
    case (ld_type)
      LD_TYPE_LB:  ld_ext = {{24{b[7]}}, b};
      LD_TYPE_LBU: ld_ext = {24'd0, b};
      LD_TYPE_LH:  ld_ext = {{16{h[15]}}, h};
      LD_TYPE_LHU: ld_ext = {16'd0, h};
      default:     ld_ext = dr;
    endcase
  endfunction

endpackage

// File: rtl/wb_stage_grf.sv
// General register file: sync reset/write, two combinational read ports with W->D bypass.
// Optional write trace enabled by `GRF_DISPLAY_EN.
module wb_stage_grf
  import wb_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_a3,
  input  logic [DW-1:0] i_wd,
  input  logic [31:0]   i_pc,
  input  logic [AW-1:0] i_ra1,
  input  logic [AW-1:0] i_ra2,
  output logic [DW-1:0] o_rd1,
  output logic [DW-1:0] o_rd2
);

  logic [NREG-1:0][DW-1:0] r_regs;

  // Reset takes priority over a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && i_a3 != '0) begin
      r_regs[i_a3] <= i_wd;
    end
  end

  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
    if (a == '0)                 rd_port = '0;
    else if (i_we && a == i_a3)  rd_port = i_wd;
    else                         rd_port = r_regs[a];
  endfunction

  assign o_rd1 = rd_port(i_ra1);
  assign o_rd2 = rd_port(i_ra2);

`ifdef GRF_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!reset && i_we && i_a3 != '0)
      $display("@%h: $%d <= %h", i_pc, i_a3, i_wd);
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = &{1'b0, i_pc};
`endif

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: load extender, write-back data mux and GRF with W->D bypass.
// Define GRF_DISPLAY_EN to print the course-format register write trace.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   ir_W,
  input  logic [31:0]   pc_W,
  input  logic [DW-1:0] ao_W,
  input  logic [DW-1:0] dr_W,
  input  logic [DW-1:0] hilo_W,
  input  logic [31:0]   control_W,
  input  logic [AW-1:0] rs_addr_D,
  input  logic [AW-1:0] rt_addr_D,
  output logic [DW-1:0] rs_data_D,
  output logic [DW-1:0] rt_data_D,
  output logic          we_W,
  output logic [AW-1:0] a3_W,
  output logic [DW-1:0] wd_W
);

  logic [AW-1:0] w_a3;
  logic [2:0]    w_wd_sel;
  logic [2:0]    w_ld_type;
  logic          w_reg_we;
  logic [DW-1:0] w_ld_data;

  assign w_a3      = control_W[CTL_A3_MSB:CTL_A3_LSB];
  assign w_wd_sel  = control_W[CTL_WDS_MSB:CTL_WDS_LSB];
  assign w_ld_type = control_W[CTL_LDT_MSB:CTL_LDT_LSB];
  assign w_reg_we  = control_W[CTL_REG_WE];

  assign w_ld_data = ld_ext(w_ld_type, ao_W[1:0], dr_W);

  always_comb begin
    wd_W = ao_W;
    case (w_wd_sel)
      WD_SEL_DR:   wd_W = w_ld_data;
      WD_SEL_PC8:  wd_W = pc_W + 32'd8;
      WD_SEL_HILO: wd_W = hilo_W;
      default:     wd_W = ao_W;
    endcase
  end

  assign we_W = w_reg_we && (w_a3 != '0);
  assign a3_W = w_a3;

  logic w_unused;
  assign w_unused = &{1'b0, ir_W, control_W[31:12]};

  wb_stage_grf #(.DW(DW)) u_grf (
    .clk   (clk),
    .reset (reset),
    .i_we  (we_W),
    .i_a3  (a3_W),
    .i_wd  (wd_W),
    .i_pc  (pc_W),
    .i_ra1 (rs_addr_D),
    .i_ra2 (rt_addr_D),
    .o_rd1 (rs_data_D),
    .o_rd2 (rt_data_D)
  );

endmodule
